// File: rtl/regfile_wen_sequencer.sv
// regfile_wen_sequencer: registered one-hot write-enable decoder with clear sweep; WEN_SEQ_R0_LOCK_EN hardwires register 0
module regfile_wen_sequencer #(
  parameter int ADDR_W = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  output logic                   wr_ready,
  input  logic                   clr_req,
  output logic [2**ADDR_W-1:0]   wen,
  output logic                   zero_sel,
  output logic                   clr_busy,
  output logic                   clr_done
);
  localparam int DEPTH = 2**ADDR_W;
  typedef enum logic {IDLE, SWEEP} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] cnt, cnt_n;
  logic [DEPTH-1:0] wen_n;
  logic zero_n, busy_n, done_n;
  assign wr_ready = (state == IDLE) && !clr_req;
  // Outputs register alongside state, so cnt holds the index for the next sweep cycle
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    wen_n = '0;
    zero_n = 1'b0;
    busy_n = 1'b0;
    done_n = 1'b0;
    if (state == IDLE) begin
      if (clr_req) begin
        state_n = SWEEP;
        cnt_n = ADDR_W'(1);
        wen_n = DEPTH'(1);
        zero_n = 1'b1;
        busy_n = 1'b1;
      end else if (wr_en) begin
        wen_n = DEPTH'(1) << wr_addr;
      end
    end else begin
      wen_n = DEPTH'(1) << cnt;
      zero_n = 1'b1;
      busy_n = 1'b1;
      cnt_n = cnt + 1'b1;
      if (cnt == ADDR_W'(DEPTH-1)) begin
        done_n = 1'b1;
        state_n = IDLE;
      end
    end
`ifdef WEN_SEQ_R0_LOCK_EN
    wen_n[0] = 1'b0;
`endif
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      wen <= '0;
      zero_sel <= 1'b0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      wen <= wen_n;
      zero_sel <= zero_n;
      clr_busy <= busy_n;
      clr_done <= done_n;
    end
  end
endmodule

// File: tb/tb_regfile_wen_sequencer.sv
// tb_regfile_wen_sequencer: directed checks of decode, sweep, collision, reset abort and ADDR_W=3
module tb_regfile_wen_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic wr_en = 1'b0, clr_req = 1'b0, wr_ready;
  logic [4:0] wr_addr = '0;
  logic [31:0] wen;
  logic zero_sel, clr_busy, clr_done;
  logic w8_en = 1'b0, c8_req = 1'b0, r8_ready;
  logic [2:0] w8_addr = '0;
  logic [7:0] wen8;
  logic z8_sel, c8_busy, c8_done;
  int vectors = 0;
  int miscompares = 0;
  always #5 clock = ~clock;
  regfile_wen_sequencer u_dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_ready(wr_ready),
    .clr_req(clr_req), .wen(wen), .zero_sel(zero_sel), .clr_busy(clr_busy), .clr_done(clr_done)
  );
  regfile_wen_sequencer #(.ADDR_W(3)) u_dut8 (
    .clock(clock), .reset(reset), .wr_en(w8_en), .wr_addr(w8_addr), .wr_ready(r8_ready),
    .clr_req(c8_req), .wen(wen8), .zero_sel(z8_sel), .clr_busy(c8_busy), .clr_done(c8_done)
  );
  function automatic logic [31:0] oh(int i);
    logic [31:0] v;
    v = 32'd1 << i;
`ifdef WEN_SEQ_R0_LOCK_EN
    v[0] = 1'b0;
`endif
    return v;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  initial begin
    step();
    step();
    chk("rst_wen", wen, 32'h0);
    chk("rst_zero", {31'b0, zero_sel}, 32'h0);
    chk("rst_busy", {31'b0, clr_busy}, 32'h0);
    chk("rst_done", {31'b0, clr_done}, 32'h0);
    reset = 1'b0;
    chk("idle_ready", {31'b0, wr_ready}, 32'h1);
    for (int a = 0; a < 32; a++) begin
      wr_en = 1'b1;
      wr_addr = 5'(a);
      step();
      chk($sformatf("dec_wen_%0d", a), wen, oh(a));
      chk("dec_zero", {31'b0, zero_sel}, 32'h0);
    end
    wr_en = 1'b0;
    step();
    chk("idle_wen", wen, 32'h0);
    clr_req = 1'b1;
    #1;
    chk("clr_ready", {31'b0, wr_ready}, 32'h0);
    step();
    clr_req = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("sw_wen_%0d", i), wen, oh(i));
      chk("sw_zero", {31'b0, zero_sel}, 32'h1);
      chk("sw_busy", {31'b0, clr_busy}, 32'h1);
      chk("sw_done", {31'b0, clr_done}, {31'b0, i == 31});
      chk("sw_ready", {31'b0, wr_ready}, {31'b0, i == 31});
      step();
    end
    chk("post_wen", wen, 32'h0);
    chk("post_busy", {31'b0, clr_busy}, 32'h0);
    chk("post_done", {31'b0, clr_done}, 32'h0);
    wr_en = 1'b1;
    wr_addr = 5'd7;
    clr_req = 1'b1;
    #1;
    chk("col_ready", {31'b0, wr_ready}, 32'h0);
    step();
    clr_req = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("col_wen_%0d", i), wen, oh(i));
      chk("col_ready_sw", {31'b0, wr_ready}, {31'b0, i == 31});
      step();
    end
    chk("col_held_wen", wen, oh(7));
    chk("col_held_zero", {31'b0, zero_sel}, 32'h0);
    wr_en = 1'b0;
    step();
    chk("col_after", wen, 32'h0);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int i = 0; i < 9; i++) step();
    chk("abort_pre", wen, oh(9));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_wen", wen, 32'h0);
    chk("abort_busy", {31'b0, clr_busy}, 32'h0);
    chk("abort_zero", {31'b0, zero_sel}, 32'h0);
    for (int i = 0; i < 30; i++) begin
      chk("abort_nodone", {31'b0, clr_done}, 32'h0);
      chk("abort_idle", wen, 32'h0);
      step();
    end
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    chk("restart_0", wen, oh(0));
    chk("restart_busy", {31'b0, clr_busy}, 32'h1);
    step();
    chk("restart_1", wen, oh(1));
    for (int i = 0; i < 31; i++) step();
    chk("restart_end", {31'b0, clr_busy}, 32'h0);
    w8_en = 1'b1;
    w8_addr = 3'd5;
    step();
    w8_en = 1'b0;
    chk("p8_wen5", {24'b0, wen8}, 32'h20);
    c8_req = 1'b1;
    step();
    c8_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("p8_sw_%0d", i), {24'b0, wen8}, oh(i) & 32'hff);
      chk("p8_busy", {31'b0, c8_busy}, 32'h1);
      chk("p8_done", {31'b0, c8_done}, {31'b0, i == 7});
      step();
    end
    chk("p8_post", {31'b0, c8_busy}, 32'h0);
    chk("p8_post_wen", {24'b0, wen8}, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
